// File: rtl/inst_loader.sv
// Streams a little-endian word count and instruction words from a byte source into
// instruction memory, holding the core in reset until the image is fully loaded.
module inst_loader #(
    parameter logic [31:0] InstStartFrom = 32'h0000_0000,
    parameter int unsigned InstSpace     = 32'h0000_4000,
    parameter logic [31:0] BASE_ADDR     = InstStartFrom,
    parameter int unsigned MAX_WORDS     = InstSpace >> 2,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        load,
    output logic [31:0] load_addr,
    output logic [31:0] load_inst,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] widx_q, widx_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] nwords_q, nwords_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        hs;

    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        widx_d   = widx_q;
        tmo_d    = tmo_q;
        nwords_d = nwords_q;
        asm_d    = asm_q;
        addr_d   = addr_q;
        inst_d   = inst_q;

        byte_ready = (state_q == StCount) || (state_q == StData);
        hs         = byte_ready && byte_valid;
        load       = (state_q == StWrite);
        done       = (state_q == StDone);
        error      = (state_q == StErr);
        cpu_hold   = (state_q == StCount) || (state_q == StData) ||
                     (state_q == StWrite) || (state_q == StErr);

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StCount;
                    bidx_d   = 2'd0;
                    widx_d   = 32'd0;
                    tmo_d    = 32'd0;
                    nwords_d = 32'd0;
                    asm_d    = 32'd0;
                end
            end
            StCount: begin
                if (hs) begin
                    tmo_d                   = 32'd0;
                    bidx_d                  = bidx_q + 2'd1;
                    nwords_d[8*bidx_q +: 8] = byte_data;
                    if (bidx_q == 2'd3) begin
                        if (nwords_d == 32'd0 || nwords_d > MAX_WORDS) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (hs) begin
                    tmo_d                = 32'd0;
                    bidx_d               = bidx_q + 2'd1;
                    asm_d[8*bidx_q +: 8] = byte_data;
                    if (bidx_q == 2'd3) begin
                        state_d = StWrite;
                        addr_d  = BASE_ADDR + (widx_q << 2);
                        inst_d  = asm_d;
                    end
                end
            end
            StWrite: begin
                widx_d  = widx_q + 32'd1;
                state_d = (widx_d == nwords_q) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase

        // Idle cycles while waiting for a byte; expiry abandons any partial word.
        if (byte_ready && !hs) begin
            tmo_d = tmo_q + 32'd1;
            if (TIMEOUT != 0 && tmo_d == TIMEOUT) begin
                state_d = StErr;
                bidx_d  = 2'd0;
                asm_d   = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            bidx_q   <= 2'd0;
            widx_q   <= 32'd0;
            tmo_q    <= 32'd0;
            nwords_q <= 32'd0;
            asm_q    <= 32'd0;
            addr_q   <= 32'd0;
            inst_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            widx_q   <= widx_d;
            tmo_q    <= tmo_d;
            nwords_q <= nwords_d;
            asm_q    <= asm_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
        end
    end

    assign load_addr = addr_q;
    assign load_inst = inst_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: two instances share one stimulus stream, one with a
// short timeout and zero base, the other with the timeout disabled and a non-zero base.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;

    logic        rdy_a, load_a, hold_a, done_a, err_a;
    logic [31:0] addr_a, inst_a;
    logic        rdy_b, load_b, hold_b, done_b, err_b;
    logic [31:0] addr_b, inst_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] la_addr[$], la_inst[$], lb_addr[$], lb_inst[$];
    logic        la_rdy[$];

    always #5 clk = ~clk;

    inst_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(4), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(rdy_a), .load(load_a), .load_addr(addr_a), .load_inst(inst_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a)
    );

    inst_loader #(.BASE_ADDR(32'h1000), .MAX_WORDS(4), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(rdy_b), .load(load_b), .load_addr(addr_b), .load_inst(inst_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b)
    );

    always @(negedge clk) begin
        if (load_a) begin
            la_addr.push_back(addr_a);
            la_inst.push_back(inst_a);
            la_rdy.push_back(rdy_a);
        end
        if (load_b) begin
            lb_addr.push_back(addr_b);
            lb_inst.push_back(inst_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 just after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (!rdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("handshake_wait", 32'd0, 32'd1);
        step();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) step();
        @(negedge clk);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_load", 32'(load_a), 32'd0);
        chk("rst_addr", addr_a, 32'h0);
        chk("rst_inst", inst_a, 32'h0);
        chk("rst_hold", 32'(hold_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_error", 32'(err_a), 32'd0);
        step();
        rst = 1'b0;

        // Bytes offered in IDLE are ignored.
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (2) step();
        byte_valid = 1'b0;
        @(negedge clk);
        chk("idle_ignore_hold", 32'(hold_a), 32'd0);
        step();

        // Two-word load.
        pulse_start();
        @(negedge clk);
        chk("count_ready", 32'(rdy_a), 32'd1);
        chk("count_hold", 32'(hold_a), 32'd1);
        step();
        send_word(32'd2);
        send_word(32'h0000_0013);
        @(negedge clk);
        chk("w0_load", 32'(load_a), 32'd1);
        chk("w0_addr", addr_a, 32'h0);
        chk("w0_inst", inst_a, 32'h0000_0013);
        chk("w0_ready", 32'(rdy_a), 32'd0);
        step();
        send_word(32'h0010_0093);
        @(negedge clk);
        chk("w1_load", 32'(load_a), 32'd1);
        chk("w1_addr", addr_a, 32'h4);
        chk("w1_inst", inst_a, 32'h0010_0093);
        step();
        @(negedge clk);
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_hold", 32'(hold_a), 32'd0);
        chk("done_load", 32'(load_a), 32'd0);
        chk("done_addr_hold", addr_a, 32'h4);
        chk("b_w0_addr", lb_addr[0], 32'h1000);
        chk("b_w1_addr", lb_addr[1], 32'h1004);
        chk("b_w1_inst", lb_inst[1], 32'h0010_0093);
        chk("two_loads", 32'(la_addr.size()), 32'd2);
        step();

        // Zero count.
        pulse_start();
        send_word(32'd0);
        @(negedge clk);
        chk("zero_err", 32'(err_a), 32'd1);
        chk("zero_hold", 32'(hold_a), 32'd1);
        chk("zero_noload", 32'(la_addr.size()), 32'd2);
        step();

        // Count above MAX_WORDS.
        pulse_start();
        @(negedge clk);
        chk("restart_err_clr", 32'(err_a), 32'd0);
        step();
        send_word(32'd5);
        @(negedge clk);
        chk("over_err", 32'(err_a), 32'd1);
        step();

        // Timeout after a partial word.
        pulse_start();
        send_word(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (7) step();
        @(negedge clk);
        chk("tmo_not_yet", 32'(err_a), 32'd0);
        step();
        @(negedge clk);
        chk("tmo_err", 32'(err_a), 32'd1);
        chk("tmo_noload", 32'(la_addr.size()), 32'd2);
        chk("tmo_disabled_b", 32'(err_b), 32'd0);
        step();

        // Reset mid-word, then a clean session.
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse_start();
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_hold", 32'(hold_a), 32'd0);
        chk("rst_mid_ready", 32'(rdy_a), 32'd0);
        step();
        pulse_start();
        send_word(32'd1);
        send_word(32'h1234_5678);
        @(negedge clk);
        chk("fresh_addr", addr_a, 32'h0);
        chk("fresh_inst", inst_a, 32'h1234_5678);
        step();
        @(negedge clk);
        chk("fresh_done", 32'(done_a), 32'd1);
        step();

        // Gapped byte stream.
        la_addr.delete();
        la_inst.delete();
        la_rdy.delete();
        lb_addr.delete();
        lb_inst.delete();
        pulse_start();
        begin
            logic [7:0] s[12];
            s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(1, 3)) step();
                send_byte(s[i]);
            end
        end
        step();
        @(negedge clk);
        chk("gap_count", 32'(la_addr.size()), 32'd2);
        chk("gap_a0", la_addr[0], 32'h0);
        chk("gap_i0", la_inst[0], 32'h0000_0013);
        chk("gap_a1", la_addr[1], 32'h4);
        chk("gap_i1", la_inst[1], 32'h0010_0093);
        chk("gap_rdy0", 32'(la_rdy[0]), 32'd0);
        chk("gap_rdy1", 32'(la_rdy[1]), 32'd0);
        chk("gap_b_a1", lb_addr[1], 32'h1004);
        chk("gap_b_i0", lb_inst[0], 32'h0000_0013);
        chk("gap_done", 32'(done_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The block SHALL take parameter BASE_ADDR, default InstStartFrom, the byte address of the first instruction word written.
REQ-002 The block SHALL take parameter MAX_WORDS, default InstSpace>>2, the largest word count accepted.
REQ-003 The block SHALL take parameter TIMEOUT, default 1000000, the maximum idle cycles between bytes; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: arms a load session.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-008 The block SHALL have port byte_data, input, 8 bits: the incoming stream byte.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 The block SHALL have port load, output, 1 bit: instruction-memory write strobe.
REQ-011 The block SHALL have port load_addr, output, addr_t (32 bits): byte address of the write.
REQ-012 The block SHALL have port load_inst, output, inst_t (32 bits): the word to write.
REQ-013 The block SHALL have port cpu_hold, output, 1 bit: holds the core in reset while a session is active.
REQ-014 The block SHALL have ports done and error, output, 1 bit each: session status.

Function
REQ-015 A byte SHALL transfer only in a cycle with byte_valid=1 and byte_ready=1.
REQ-016 The stream format SHALL be a 4-byte little-endian word count N, followed by N words of 4 little-endian bytes each (first byte = bits [7:0]).
REQ-017 The FSM SHALL have states IDLE, COUNT, DATA, WRITE, DONE and ERR.
REQ-018 In IDLE: byte_ready=0; start=1 moves to COUNT and clears the byte index, word index and timeout counter.
REQ-019 In COUNT: byte_ready=1; on the 4th accepted byte, N=0 or N>MAX_WORDS moves to ERR, otherwise to DATA.
REQ-020 In DATA: byte_ready=1; bytes are assembled into a word; the 4th accepted byte moves to WRITE in the next cycle.
REQ-021 In WRITE: byte_ready=0; load=1 for exactly one cycle; load_addr=BASE_ADDR+4*widx (32-bit wrap); load_inst holds the assembled word.
REQ-022 On leaving WRITE, widx SHALL increment; the next state is DONE if widx+1==N, otherwise DATA.
REQ-023 Per word the latency SHALL be the 4th byte handshake at cycle t, with load asserted at cycle t+1.
REQ-024 Outside WRITE, load SHALL be 0; load_addr and load_inst hold their last values.
REQ-025 The timeout counter SHALL increment each cycle in COUNT or DATA without a byte handshake and clear on each handshake.
REQ-026 When the timeout counter reaches TIMEOUT (TIMEOUT≠0), the FSM SHALL go to ERR and discard any partial word.
REQ-027 done=1 SHALL be held exactly in DONE, and error=1 exactly in ERR.
REQ-028 From DONE or ERR, start=1 SHALL begin a new session (go to COUNT with counters cleared); start SHALL be ignored in COUNT, DATA and WRITE.
REQ-029 cpu_hold SHALL be 1 in COUNT, DATA, WRITE and ERR, and 0 in IDLE and DONE.
REQ-030 Bytes offered while byte_ready=0 SHALL NOT be consumed and SHALL NOT affect state.

Reset
REQ-031 rst=1 SHALL force IDLE in the next cycle from any state, including mid-word and during WRITE, with no load pulse in that cycle.
REQ-032 The reset values SHALL be: byte_ready=0, load=0, load_addr=0, load_inst=0, cpu_hold=0, done=0, error=0, with all counters and the assembly register at 0.
REQ-033 rst SHALL take priority over start and byte handshakes in the same cycle.

Verification
REQ-034 BASE_ADDR=0; start, then bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> two load pulses: (0x0, 0x00000013), then (0x4, 0x00100093); then done=1, cpu_hold=0.
REQ-035 Count bytes 00 00 00 00 -> error=1, cpu_hold=1, and no load pulse ever.
REQ-036 MAX_WORDS=4, count 05 00 00 00 -> error=1 after the 4th count byte.
REQ-037 TIMEOUT=8, N=1, only 2 data bytes sent -> error=1 exactly 8 idle cycles after the last handshake, and no load.
REQ-038 rst asserted after the 2nd data byte, then a new full session -> the first write is at BASE_ADDR with only the new bytes (no stale partial-word bytes).
REQ-039 byte_valid toggled randomly with 1-3 cycle gaps (TIMEOUT=0) -> the same writes as REQ-034; byte_ready is 0 on every WRITE cycle.
